// File: rtl/multicycle_control.sv
// multicycle_control
// Main control FSM for a multicycle RISC-V core. Each instruction is sequenced
// through fetch, decode, execute, memory and writeback states. The FSM drives
// every datapath select and write strobe, and it issues the 3-bit ALU control
// code. The ALU N/Z/C/V flags are consumed in the same cycle to resolve
// conditional branches.
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   opcode/funct3/funct7b5 instruction fields from the instruction register
//   mem_ready             memory completes the current access this cycle
//   n/z/c/v_flag          ALU flags, valid in the same cycle
//   alu_control           000 add, 001 sub, 010 and, 011 or, 101 slt
//   alu_src_a/alu_src_b   ALU operand selects
//   result_src, imm_src   result mux select, immediate format select
//   adr_src               memory address select (0 PC, 1 result)
//   ir/pc/reg/mem_write   write strobes
//   instr_done            pulse in the final cycle of each instruction
//   illegal               pulse in DECODE on an unsupported opcode
module multicycle_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       mem_ready,
  input  logic       n_flag,
  input  logic       z_flag,
  input  logic       c_flag,
  input  logic       v_flag,
  output logic [2:0] alu_control,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [1:0] imm_src,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic       mem_write,
  output logic       instr_done,
  output logic       illegal
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  state_t     r_state;
  state_t     w_next;
  logic [2:0] w_funct_alu;
  logic       w_take;
  logic       w_ir_write;
  logic       w_pc_write;
  logic       w_reg_write;
  logic       w_mem_write;
  logic       w_instr_done;
  logic       w_illegal;

  // State register; reset restarts sequencing at FETCH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // ALU code for R/I-type execute; sub only for R-type with funct7b5 set
  always_comb begin
    w_funct_alu = 3'b000;
    case (funct3)
      3'b000: begin
        if ((opcode == OP_R) && funct7b5) begin
          w_funct_alu = 3'b001;
        end else begin
          w_funct_alu = 3'b000;
        end
      end
      3'b010:  w_funct_alu = 3'b101;
      3'b110:  w_funct_alu = 3'b011;
      3'b111:  w_funct_alu = 3'b010;
      default: w_funct_alu = 3'b000;
    endcase
  end

  // Branch condition from same-cycle flags of the rs1 - rs2 subtraction
  always_comb begin
    w_take = 1'b0;
    case (funct3)
      3'b000:  w_take = z_flag;
      3'b001:  w_take = ~z_flag;
      3'b100:  w_take = n_flag ^ v_flag;
      3'b101:  w_take = ~(n_flag ^ v_flag);
      3'b110:  w_take = ~c_flag;
      3'b111:  w_take = c_flag;
      default: w_take = 1'b0;
    endcase
  end

  // Immediate format depends only on the opcode
  always_comb begin
    imm_src = 2'b00;
    case (opcode)
      OP_LW, OP_I: imm_src = 2'b00;
      OP_SW:       imm_src = 2'b01;
      OP_BR:       imm_src = 2'b10;
      OP_JAL:      imm_src = 2'b11;
      default:     imm_src = 2'b00;
    endcase
  end

  // Next-state and per-state select/strobe decode
  always_comb begin
    w_next       = r_state;
    alu_control  = 3'b000;
    alu_src_a    = 2'b00;
    alu_src_b    = 2'b00;
    result_src   = 2'b00;
    adr_src      = 1'b0;
    w_ir_write   = 1'b0;
    w_pc_write   = 1'b0;
    w_reg_write  = 1'b0;
    w_mem_write  = 1'b0;
    w_instr_done = 1'b0;
    w_illegal    = 1'b0;
    case (r_state)
      S_FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        w_ir_write = mem_ready;
        w_pc_write = mem_ready;
        if (mem_ready) begin
          w_next = S_DECODE;
        end else begin
          w_next = S_FETCH;
        end
      end
      S_DECODE: begin
        // PC-relative target precomputed into ALUOut for branches
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (opcode)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R:         w_next = S_EXEC_R;
          OP_I:         w_next = S_EXEC_I;
          OP_BR:        w_next = S_BRANCH;
          OP_JAL:       w_next = S_JAL;
          default: begin
            w_next    = S_FETCH;
            w_illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        if (opcode == OP_SW) begin
          w_next = S_MEMWRITE;
        end else begin
          w_next = S_MEMREAD;
        end
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        if (mem_ready) begin
          w_next = S_MEMWB;
        end else begin
          w_next = S_MEMREAD;
        end
      end
      S_MEMWB: begin
        result_src   = 2'b01;
        w_reg_write  = 1'b1;
        w_instr_done = 1'b1;
        w_next       = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src     = 1'b1;
        w_mem_write = 1'b1;
        if (mem_ready) begin
          w_instr_done = 1'b1;
          w_next       = S_FETCH;
        end else begin
          w_next = S_MEMWRITE;
        end
      end
      S_EXEC_R: begin
        alu_src_a   = 2'b10;
        alu_control = w_funct_alu;
        w_next      = S_ALUWB;
      end
      S_EXEC_I: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b01;
        alu_control = w_funct_alu;
        w_next      = S_ALUWB;
      end
      S_ALUWB: begin
        w_reg_write  = 1'b1;
        w_instr_done = 1'b1;
        w_next       = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a    = 2'b10;
        alu_control  = 3'b001;
        w_pc_write   = w_take;
        w_instr_done = 1'b1;
        w_next       = S_FETCH;
      end
      S_JAL: begin
        // Return address PC+4 computed from oldPC; target already in ALUOut
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        w_pc_write = 1'b1;
        w_next     = S_ALUWB;
      end
      default: begin
        w_next = S_FETCH;
      end
    endcase
  end

  // Strobes are gated by rst_n so mem_ready cannot leak through during reset
  assign ir_write   = w_ir_write   & rst_n;
  assign pc_write   = w_pc_write   & rst_n;
  assign reg_write  = w_reg_write  & rst_n;
  assign mem_write  = w_mem_write  & rst_n;
  assign instr_done = w_instr_done & rst_n;
  assign illegal    = w_illegal    & rst_n;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

  logic       clk;
  logic       rst_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       mem_ready;
  logic       n_flag, z_flag, c_flag, v_flag;
  logic [2:0] alu_control;
  logic [1:0] alu_src_a, alu_src_b, result_src, imm_src;
  logic       adr_src, ir_write, pc_write, reg_write, mem_write, instr_done, illegal;

  int n_cmp;
  int n_err;

  // Observed output bundle: {alu, src_a, src_b, result_src, imm_src, adr_src,
  // ir_write, pc_write, reg_write, mem_write, instr_done, illegal}
  logic [17:0] w_obs;
  assign w_obs = {alu_control, alu_src_a, alu_src_b, result_src, imm_src, adr_src,
                  ir_write, pc_write, reg_write, mem_write, instr_done, illegal};

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
    .mem_ready(mem_ready), .n_flag(n_flag), .z_flag(z_flag), .c_flag(c_flag),
    .v_flag(v_flag), .alu_control(alu_control), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .result_src(result_src), .imm_src(imm_src),
    .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write),
    .reg_write(reg_write), .mem_write(mem_write), .instr_done(instr_done),
    .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packs hand-written expected fields; st = {ir, pc, reg, memw, done, illegal}
  function automatic logic [17:0] pk(input logic [2:0] a, input logic [1:0] sa,
                                     input logic [1:0] sb, input logic [1:0] rs,
                                     input logic [1:0] im, input logic ad,
                                     input logic [5:0] st);
    return {a, sa, sb, rs, im, ad, st};
  endfunction

  task automatic test_reset;
    rst_n = 1'b0; mem_ready = 1'b1; opcode = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0;
    {n_flag, z_flag, c_flag, v_flag} = 4'b0000;
    #3;
    n_cmp++;
    if (w_obs !== pk(3'd0, 2'd0, 2'd2, 2'd2, 2'd0, 1'b0, 6'b000000)) begin
      n_err++; $display("FAIL reset_hold got %h exp %h", w_obs, pk(3'd0, 2'd0, 2'd2, 2'd2, 2'd0, 1'b0, 6'b000000));
    end
    @(posedge clk); #1;
    n_cmp++;
    if (w_obs !== pk(3'd0, 2'd0, 2'd2, 2'd2, 2'd0, 1'b0, 6'b000000)) begin
      n_err++; $display("FAIL reset_edge got %h exp %h", w_obs, pk(3'd0, 2'd0, 2'd2, 2'd2, 2'd0, 1'b0, 6'b000000));
    end
    #5; mem_ready = 1'b0; rst_n = 1'b1; #1;
    n_cmp++;
    if (w_obs !== pk(3'd0, 2'd0, 2'd2, 2'd2, 2'd0, 1'b0, 6'b000000)) begin
      n_err++; $display("FAIL reset_release got %h exp %h", w_obs, pk(3'd0, 2'd0, 2'd2, 2'd2, 2'd0, 1'b0, 6'b000000));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_add;
    logic [17:0] ev [5];
    logic        rdy [5];
    ev = '{pk(3'd0, 2'd0, 2'd2, 2'd2, 2'd0, 1'b0, 6'b110000),
           pk(3'd0, 2'd1, 2'd1, 2'd0, 2'd0, 1'b0, 6'b000000),
           pk(3'd0, 2'd2, 2'd0, 2'd0, 2'd0, 1'b0, 6'b000000),
           pk(3'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 6'b001010),
           pk(3'd0, 2'd0, 2'd2, 2'd2, 2'd0, 1'b0, 6'b000000)};
    rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    opcode = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      mem_ready = rdy[i]; #1;
      n_cmp++;
      if (w_obs !== ev[i]) begin
        n_err++; $display("FAIL add cyc%0d got %h exp %h", i + 1, w_obs, ev[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_alu_ops;
    logic [6:0] ops [7];
    logic [2:0] f3s [7];
    logic       f7s [7];
    logic [2:0] alus [7];
    logic [1:0] sbs [7];
    logic [17:0] ev [4];
    ops  = '{7'b0110011, 7'b0010011, 7'b0110011, 7'b0010011, 7'b0010011, 7'b0110011, 7'b0110011};
    f3s  = '{3'b000, 3'b000, 3'b010, 3'b110, 3'b111, 3'b111, 3'b001};
    f7s  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    alus = '{3'b001, 3'b000, 3'b101, 3'b011, 3'b010, 3'b010, 3'b000};
    sbs  = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd1, 2'd0, 2'd0};
    mem_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      opcode = ops[k]; funct3 = f3s[k]; funct7b5 = f7s[k];
      ev = '{pk(3'd0, 2'd0, 2'd2, 2'd2, 2'd0, 1'b0, 6'b110000),
             pk(3'd0, 2'd1, 2'd1, 2'd0, 2'd0, 1'b0, 6'b000000),
             pk(alus[k], 2'd2, sbs[k], 2'd0, 2'd0, 1'b0, 6'b000000),
             pk(3'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 6'b001010)};
      for (int i = 0; i < 4; i++) begin
        #1;
        n_cmp++;
        if (w_obs !== ev[i]) begin
          n_err++; $display("FAIL alu_op%0d cyc%0d got %h exp %h", k, i + 1, w_obs, ev[i]);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_branch;
    logic [2:0]  f3s [9];
    logic [3:0]  flg [9];
    logic        tk [9];
    logic [17:0] ev [3];
    // flags packed {n, z, c, v}
    f3s = '{3'b100, 3'b100, 3'b111, 3'b000, 3'b001, 3'b101, 3'b110, 3'b010, 3'b000};
    flg = '{4'b1000, 4'b1001, 4'b0010, 4'b0000, 4'b0000, 4'b1001, 4'b0010, 4'b0100, 4'b0100};
    tk  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    opcode = 7'b1100011; funct7b5 = 1'b0; mem_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      funct3 = f3s[k]; {n_flag, z_flag, c_flag, v_flag} = flg[k];
      ev = '{pk(3'd0, 2'd0, 2'd2, 2'd2, 2'd2, 1'b0, 6'b110000),
             pk(3'd0, 2'd1, 2'd1, 2'd0, 2'd2, 1'b0, 6'b000000),
             pk(3'd1, 2'd2, 2'd0, 2'd0, 2'd2, 1'b0, {1'b0, tk[k], 4'b0010})};
      for (int i = 0; i < 3; i++) begin
        #1;
        n_cmp++;
        if (w_obs !== ev[i]) begin
          n_err++; $display("FAIL branch%0d cyc%0d got %h exp %h", k, i + 1, w_obs, ev[i]);
        end
        @(posedge clk); #1;
      end
    end
    {n_flag, z_flag, c_flag, v_flag} = 4'b0000;
  endtask

  task automatic test_lw_wait;
    logic [17:0] ev [9];
    logic        rdy [9];
    ev = '{pk(3'd0, 2'd0, 2'd2, 2'd2, 2'd0, 1'b0, 6'b000000),
           pk(3'd0, 2'd0, 2'd2, 2'd2, 2'd0, 1'b0, 6'b000000),
           pk(3'd0, 2'd0, 2'd2, 2'd2, 2'd0, 1'b0, 6'b110000),
           pk(3'd0, 2'd1, 2'd1, 2'd0, 2'd0, 1'b0, 6'b000000),
           pk(3'd0, 2'd2, 2'd1, 2'd0, 2'd0, 1'b0, 6'b000000),
           pk(3'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1, 6'b000000),
           pk(3'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1, 6'b000000),
           pk(3'd0, 2'd0, 2'd0, 2'd1, 2'd0, 1'b0, 6'b001010),
           pk(3'd0, 2'd0, 2'd2, 2'd2, 2'd0, 1'b0, 6'b000000)};
    rdy = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    opcode = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0;
    for (int i = 0; i < 9; i++) begin
      mem_ready = rdy[i]; #1;
      n_cmp++;
      if (w_obs !== ev[i]) begin
        n_err++; $display("FAIL lw cyc%0d got %h exp %h", i + 1, w_obs, ev[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_sw_wait;
    logic [17:0] ev [8];
    logic        rdy [8];
    ev = '{pk(3'd0, 2'd0, 2'd2, 2'd2, 2'd1, 1'b0, 6'b110000),
           pk(3'd0, 2'd1, 2'd1, 2'd0, 2'd1, 1'b0, 6'b000000),
           pk(3'd0, 2'd2, 2'd1, 2'd0, 2'd1, 1'b0, 6'b000000),
           pk(3'd0, 2'd0, 2'd0, 2'd0, 2'd1, 1'b1, 6'b000100),
           pk(3'd0, 2'd0, 2'd0, 2'd0, 2'd1, 1'b1, 6'b000100),
           pk(3'd0, 2'd0, 2'd0, 2'd0, 2'd1, 1'b1, 6'b000100),
           pk(3'd0, 2'd0, 2'd0, 2'd0, 2'd1, 1'b1, 6'b000110),
           pk(3'd0, 2'd0, 2'd2, 2'd2, 2'd1, 1'b0, 6'b000000)};
    rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    opcode = 7'b0100011; funct3 = 3'b010; funct7b5 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      mem_ready = rdy[i]; #1;
      n_cmp++;
      if (w_obs !== ev[i]) begin
        n_err++; $display("FAIL sw cyc%0d got %h exp %h", i + 1, w_obs, ev[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_jal;
    logic [17:0] ev [5];
    logic        rdy [5];
    ev = '{pk(3'd0, 2'd0, 2'd2, 2'd2, 2'd3, 1'b0, 6'b110000),
           pk(3'd0, 2'd1, 2'd1, 2'd0, 2'd3, 1'b0, 6'b000000),
           pk(3'd0, 2'd1, 2'd2, 2'd0, 2'd3, 1'b0, 6'b010000),
           pk(3'd0, 2'd0, 2'd0, 2'd0, 2'd3, 1'b0, 6'b001010),
           pk(3'd0, 2'd0, 2'd2, 2'd2, 2'd3, 1'b0, 6'b000000)};
    rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    opcode = 7'b1101111; funct3 = 3'b000; funct7b5 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      mem_ready = rdy[i]; #1;
      n_cmp++;
      if (w_obs !== ev[i]) begin
        n_err++; $display("FAIL jal cyc%0d got %h exp %h", i + 1, w_obs, ev[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal;
    logic [17:0] ev [3];
    logic        rdy [3];
    ev = '{pk(3'd0, 2'd0, 2'd2, 2'd2, 2'd0, 1'b0, 6'b110000),
           pk(3'd0, 2'd1, 2'd1, 2'd0, 2'd0, 1'b0, 6'b000001),
           pk(3'd0, 2'd0, 2'd2, 2'd2, 2'd0, 1'b0, 6'b000000)};
    rdy = '{1'b1, 1'b1, 1'b0};
    opcode = 7'b1110011; funct3 = 3'b000; funct7b5 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mem_ready = rdy[i]; #1;
      n_cmp++;
      if (w_obs !== ev[i]) begin
        n_err++; $display("FAIL illegal cyc%0d got %h exp %h", i + 1, w_obs, ev[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid;
    logic [17:0] ev [4];
    logic        rdy [4];
    ev = '{pk(3'd0, 2'd0, 2'd2, 2'd2, 2'd0, 1'b0, 6'b110000),
           pk(3'd0, 2'd1, 2'd1, 2'd0, 2'd0, 1'b0, 6'b000000),
           pk(3'd0, 2'd2, 2'd1, 2'd0, 2'd0, 1'b0, 6'b000000),
           pk(3'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1, 6'b000000)};
    rdy = '{1'b1, 1'b1, 1'b1, 1'b0};
    opcode = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_ready = rdy[i]; #1;
      n_cmp++;
      if (w_obs !== ev[i]) begin
        n_err++; $display("FAIL rstmid cyc%0d got %h exp %h", i + 1, w_obs, ev[i]);
      end
      if (i < 3) begin
        @(posedge clk); #1;
      end else begin
        #1;
      end
    end
    // Reset lands in MEMREAD with memory ready: strobes must stay low
    mem_ready = 1'b1; rst_n = 1'b0; #1;
    n_cmp++;
    if (w_obs !== pk(3'd0, 2'd0, 2'd2, 2'd2, 2'd0, 1'b0, 6'b000000)) begin
      n_err++; $display("FAIL rstmid_assert got %h exp %h", w_obs, pk(3'd0, 2'd0, 2'd2, 2'd2, 2'd0, 1'b0, 6'b000000));
    end
    @(posedge clk); #1;
    n_cmp++;
    if (w_obs !== pk(3'd0, 2'd0, 2'd2, 2'd2, 2'd0, 1'b0, 6'b000000)) begin
      n_err++; $display("FAIL rstmid_held got %h exp %h", w_obs, pk(3'd0, 2'd0, 2'd2, 2'd2, 2'd0, 1'b0, 6'b000000));
    end
    rst_n = 1'b1; #1;
    n_cmp++;
    if (w_obs !== pk(3'd0, 2'd0, 2'd2, 2'd2, 2'd0, 1'b0, 6'b110000)) begin
      n_err++; $display("FAIL rstmid_fetch got %h exp %h", w_obs, pk(3'd0, 2'd0, 2'd2, 2'd2, 2'd0, 1'b0, 6'b110000));
    end
    @(posedge clk); #1;
    n_cmp++;
    if (w_obs !== pk(3'd0, 2'd1, 2'd1, 2'd0, 2'd0, 1'b0, 6'b000000)) begin
      n_err++; $display("FAIL rstmid_decode got %h exp %h", w_obs, pk(3'd0, 2'd1, 2'd1, 2'd0, 2'd0, 1'b0, 6'b000000));
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_add();
    test_alu_ops();
    test_branch();
    test_lw_wait();
    test_sw_wait();
    test_jal();
    test_illegal();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
